oup_phymodel_regs: RTL and testbench
====================================

Name: oup_phymodel_regs

Overview:
Synthesizable, parametrised ULPI PHY register-access model for link-layer benches and FPGA loopback. It services immediate and extended register writes and reads, set/clear aliasing and self-clearing soft reset. Stall (NXT) latency and extended register depth are configurable, and a write-observation port is provided. It sits on the PHY side of the ULPI bus, opposite the link under test.

Parameters:
NXT_DELAY, 0, idle cycles inserted before NXT acknowledges a TXCMD (0..15)
EXT_DEPTH, 16, implemented extended registers at 0x40..0x40+EXT_DEPTH-1 (1..192)
VID, 16'hABCD, vendor ID returned at 0x00/0x01 (low/high)
PID, 16'h1234, product ID returned at 0x02/0x03
RST_CYCLES, 4, DIR-high cycles after a soft reset (>=1)

Ports:
clk_i  in  1  ULPI clock
rst_i  in  1  synchronous reset, active-high
ulpi_data_i  in  8  link-driven bus
ulpi_data_o  out  8  PHY-driven bus, valid while dir_o=1
ulpi_dir_o  out  1  bus direction, 1 = PHY drives
ulpi_stp_i  in  1  link stop
ulpi_nxt_o  out  1  PHY throttle/acknowledge
wr_valid_o  out  1  one-cycle pulse on committed write
wr_addr_o  out  8  committed address (as issued, before set/clear aliasing)
wr_data_o  out  8  committed data
err_o  out  1  sticky protocol error

Behaviour:
- All outputs are registered. While rst_i=1: dir_o=1, data_o=0, nxt_o=0, wr_valid_o=0, err_o=0, registers reloaded to defaults, state RST. The first edge with rst_i=0 moves to IDLE with dir_o=0.
- Register defaults: FUNCTION_CTRL 0x04 = 0x41; OTG_CTRL 0x0A = 0x06; USB_INT_EN_RISE/FALL 0x0D/0x10 = 0x1F; all others 0; extended registers 0.
- Set/clear aliases on bases 0x04, 0x07, 0x0A, 0x0D, 0x10, 0x16, 0x19, 0x1D, 0x31:
  - base+1 write: reg |= data.
  - base+2 write: reg &= ~data.
  - All three addresses read the base value.
- 0x00-0x03 are read-only and return VID/PID.
- 0x13 and 0x15 are read-only and return 0.
- Writes to read-only or unmapped addresses are acknowledged and pulse wr_valid_o, but change nothing. Unmapped reads return 0x00.
- Extended address A (cmd[5:0]=0x2F):
  - 0x40 <= A < 0x40+EXT_DEPTH: normal storage.
  - A < 0x40: aliases the immediate map.
  - Any other A: reads 0, writes ignored.
- IDLE decodes ulpi_data_i every cycle:
  - 0x00: NOOP, stay.
  - 10xxxxxx: REGW.
  - 11xxxxxx: REGR.
  - 01xxxxxx: TX. NXT is held high after the delay until stp; data is discarded; back to IDLE.
  - 00xxxxxx nonzero, or any X bit: err_o=1, stay IDLE (no lock).
- Command acknowledge: the command is seen at edge t. DELAY counts NXT_DELAY cycles, then nxt_o=1 for one cycle and the command is latched at that cycle's closing edge. The link must hold the command until that edge; a changed command during DELAY sets err_o and returns to IDLE.
- REGW: each data phase is one cycle with nxt_o=1. Phases are the extended address (if extended) and then write data, each latched at the edge closing its nxt cycle. The cycle after the last phase has nxt_o=0.
  - stp_i=1 there: commit. wr_valid_o is high for the next cycle.
  - stp_i=0 there: err_o=1, no commit.
  - Return to IDLE either way.
- stp_i=1 during any earlier REGW phase: abort, no commit, no error, IDLE.
- REGR: after the command nxt (and the extended address nxt if extended), the sequence is:
  - TURN1: dir_o=1, data_o=0.
  - RDATA: dir_o=1, data_o=register value sampled at the TURN1 edge.
  - TURN2: dir_o=0.
  - Then IDLE.
- Soft reset: a committed write that leaves FUNCTION_CTRL[5]=1 does the following on the next edge:
  - Reloads all defaults, which clears bit 5.
  - Holds dir_o=1 for RST_CYCLES cycles.
  - Returns to IDLE.
  - err_o is retained.
- rst_i mid-transaction: immediate abort, no commit.

Test Plan:
- Reset release -> dir_o 1 during rst, 0 one cycle after; read 0x00..0x03 returns CD, AB, 34, 12.
- NXT_DELAY=0: link sends 0x96, 0x5A, then stp -> nxt on the cycle after cmd and on the data cycle; wr_valid_o with addr 0x16 / data 0x5A; read 0x16 = 0x5A.
- Set/clear on 0x0A (=0x06): write 0x0B=0x81 -> 0x87; write 0x0C=0x06 -> 0x81; reads of 0x0B/0x0C return 0x81.
- NXT_DELAY=3: extended write 0xAF, addr 0x45, data 0x3C -> first nxt 4 cycles after cmd; extended read of 0x45 returns 0x3C in RDATA; extended write to 0x40+EXT_DEPTH reads back 0.
- stp asserted during the data phase of a REGW to 0x16 -> no wr_valid_o, 0x16 unchanged, err_o=0; reserved cmd 0x05 -> err_o=1 sticky.
- Write 0x05=0x20 -> dir_o high for RST_CYCLES cycles; FUNCTION_CTRL reads 0x41; scratch 0x16 back to 0.

Source files
------------

// File: rtl/oup_phymodel_regs_if.sv
// ULPI bus bundle between a link (master) and the PHY register model (slave).
interface oup_phymodel_regs_if;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_dir_o;
    logic       ulpi_stp_i;
    logic       ulpi_nxt_o;

    modport master (
        output ulpi_data_i,
        output ulpi_stp_i,
        input  ulpi_data_o,
        input  ulpi_dir_o,
        input  ulpi_nxt_o
    );

    modport slave (
        input  ulpi_data_i,
        input  ulpi_stp_i,
        output ulpi_data_o,
        output ulpi_dir_o,
        output ulpi_nxt_o
    );
endinterface

// File: rtl/oup_phymodel_regs.sv
// ULPI PHY register-access model: immediate/extended register reads and
// writes, set/clear aliases, configurable NXT latency, soft reset and a
// write-observation port. All outputs come straight from flops.
module oup_phymodel_regs #(
    parameter int unsigned NXT_DELAY  = 0,
    parameter int unsigned EXT_DEPTH  = 16,
    parameter logic [15:0] VID        = 16'hABCD,
    parameter logic [15:0] PID        = 16'h1234,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    oup_phymodel_regs_if.slave        ulpi,
    output logic                      wr_valid_o,
    output logic [7:0]                wr_addr_o,
    output logic [7:0]                wr_data_o,
    output logic                      err_o
);
    localparam int unsigned NBASE    = 9;
    localparam int unsigned EXT_END  = 32'd64 + EXT_DEPTH;
    localparam int unsigned EW       = (EXT_DEPTH > 32'd1) ? $clog2(EXT_DEPTH) : 1;
    localparam logic [15:0] DLY_LAST = (NXT_DELAY > 32'd0) ? 16'(NXT_DELAY - 32'd1) : 16'd0;
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 32'd1);

    typedef enum logic [3:0] {
        ST_RST, ST_IDLE, ST_DELAY, ST_CMDACK, ST_ADDR, ST_WDATA,
        ST_WEND, ST_TURN1, ST_RDATA, ST_TURN2, ST_TXNXT, ST_SRST
    } state_t;

    state_t      state_r, state_n;
    logic [7:0]  cmd_r, ext_addr_r, wdata_r;
    logic [15:0] cnt_r;
    logic        err_r, wr_valid_r, dir_r, nxt_r;
    logic [7:0]  wr_addr_r, wr_data_r, data_r;
    logic [7:0]  imm_r [0:NBASE-1];
    logic [7:0]  ext_r [0:EXT_DEPTH-1];

    logic        seen_s, err_set_s, commit_s, is_wr_s, is_ext_s, in_imm_s, in_ext_s;
    logic [7:0]  acc_addr_s, ext_off_s, rd_val_s, wr_val_s, func_after_s;
    logic [3:0]  idx_s;
    logic [5:0]  alias_off_s;

    // Storage slot of a set/clear triple (base, base+1 set, base+2 clear); 4'hF = none.
    function automatic logic [3:0] base_idx(input logic [5:0] a);
        case (a)
            6'h04, 6'h05, 6'h06: base_idx = 4'd0;
            6'h07, 6'h08, 6'h09: base_idx = 4'd1;
            6'h0A, 6'h0B, 6'h0C: base_idx = 4'd2;
            6'h0D, 6'h0E, 6'h0F: base_idx = 4'd3;
            6'h10, 6'h11, 6'h12: base_idx = 4'd4;
            6'h16, 6'h17, 6'h18: base_idx = 4'd5;
            6'h19, 6'h1A, 6'h1B: base_idx = 4'd6;
            6'h1D, 6'h1E, 6'h1F: base_idx = 4'd7;
            6'h31, 6'h32, 6'h33: base_idx = 4'd8;
            default:             base_idx = 4'hF;
        endcase
    endfunction

    function automatic logic [5:0] base_addr(input logic [3:0] i);
        case (i)
            4'd0:    base_addr = 6'h04;
            4'd1:    base_addr = 6'h07;
            4'd2:    base_addr = 6'h0A;
            4'd3:    base_addr = 6'h0D;
            4'd4:    base_addr = 6'h10;
            4'd5:    base_addr = 6'h16;
            4'd6:    base_addr = 6'h19;
            4'd7:    base_addr = 6'h1D;
            4'd8:    base_addr = 6'h31;
            default: base_addr = 6'h00;
        endcase
    endfunction

    function automatic logic [7:0] reg_default(input logic [3:0] i);
        case (i)
            4'd0:       reg_default = 8'h41;
            4'd2:       reg_default = 8'h06;
            4'd3, 4'd4: reg_default = 8'h1F;
            default:    reg_default = 8'h00;
        endcase
    endfunction

    // TX commands hold NXT until STP; everything else gets a single-cycle ack.
    function automatic state_t ack_state(input logic [1:0] kind);
        if (kind == 2'b01) begin
            ack_state = ST_TXNXT;
        end else begin
            ack_state = ST_CMDACK;
        end
    endfunction

    assign is_wr_s  = (cmd_r[7:6] == 2'b10);
    assign is_ext_s = (cmd_r[5:0] == 6'h2F);

    // Address decode shared by reads and writes: read value and post-alias write value.
    always_comb begin
        acc_addr_s  = is_ext_s ? ext_addr_r : {2'b00, cmd_r[5:0]};
        idx_s       = base_idx(acc_addr_s[5:0]);
        alias_off_s = acc_addr_s[5:0] - base_addr(idx_s);
        ext_off_s   = acc_addr_s - 8'h40;
        in_imm_s    = 1'b0;
        in_ext_s    = 1'b0;
        rd_val_s    = 8'h00;
        wr_val_s    = wdata_r;
        if (acc_addr_s < 8'h40) begin
            if (idx_s != 4'hF) begin
                in_imm_s = 1'b1;
                rd_val_s = imm_r[idx_s];
                case (alias_off_s)
                    6'd1:    wr_val_s = imm_r[idx_s] | wdata_r;
                    6'd2:    wr_val_s = imm_r[idx_s] & ~wdata_r;
                    default: wr_val_s = wdata_r;
                endcase
            end else begin
                case (acc_addr_s[5:0])
                    6'h00:   rd_val_s = VID[7:0];
                    6'h01:   rd_val_s = VID[15:8];
                    6'h02:   rd_val_s = PID[7:0];
                    6'h03:   rd_val_s = PID[15:8];
                    default: rd_val_s = 8'h00;
                endcase
            end
        end else if (32'(acc_addr_s) < EXT_END) begin
            in_ext_s = 1'b1;
            rd_val_s = ext_r[ext_off_s[EW-1:0]];
        end else begin
            rd_val_s = 8'h00;
        end
        func_after_s = (in_imm_s && (idx_s == 4'd0)) ? wr_val_s : imm_r[0];
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state and transaction events.
    always_comb begin
        state_n   = state_r;
        seen_s    = 1'b0;
        err_set_s = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_RST: state_n = ST_IDLE;
            ST_IDLE: begin
                if ($isunknown(ulpi.ulpi_data_i)) begin
                    err_set_s = 1'b1;
                end else if (ulpi.ulpi_data_i == 8'h00) begin
                    state_n = ST_IDLE;
                end else if (ulpi.ulpi_data_i[7:6] == 2'b00) begin
                    err_set_s = 1'b1;
                end else begin
                    seen_s  = 1'b1;
                    state_n = (NXT_DELAY != 32'd0) ? ST_DELAY : ack_state(ulpi.ulpi_data_i[7:6]);
                end
            end
            ST_DELAY: begin
                if (ulpi.ulpi_data_i != cmd_r) begin
                    err_set_s = 1'b1;
                    state_n   = ST_IDLE;
                end else if (cnt_r == DLY_LAST) begin
                    state_n = ack_state(cmd_r[7:6]);
                end else begin
                    state_n = ST_DELAY;
                end
            end
            ST_CMDACK: begin
                if (is_wr_s) begin
                    if (ulpi.ulpi_stp_i) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = is_ext_s ? ST_ADDR : ST_WDATA;
                    end
                end else begin
                    state_n = is_ext_s ? ST_ADDR : ST_TURN1;
                end
            end
            ST_ADDR: begin
                if (is_wr_s) begin
                    state_n = ulpi.ulpi_stp_i ? ST_IDLE : ST_WDATA;
                end else begin
                    state_n = ST_TURN1;
                end
            end
            ST_WDATA: state_n = ulpi.ulpi_stp_i ? ST_IDLE : ST_WEND;
            ST_WEND: begin
                if (ulpi.ulpi_stp_i) begin
                    commit_s = 1'b1;
                    state_n  = func_after_s[5] ? ST_SRST : ST_IDLE;
                end else begin
                    err_set_s = 1'b1;
                    state_n   = ST_IDLE;
                end
            end
            ST_TURN1: state_n = ST_RDATA;
            ST_RDATA: state_n = ST_TURN2;
            ST_TURN2: state_n = ST_IDLE;
            ST_TXNXT: state_n = ulpi.ulpi_stp_i ? ST_IDLE : ST_TXNXT;
            ST_SRST:  state_n = (cnt_r == RST_LAST) ? ST_IDLE : ST_SRST;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Register file: defaults on reset and throughout soft reset, else commit writes.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_r == ST_SRST)) begin
            for (int unsigned i = 0; i < NBASE; i++) begin
                imm_r[i] <= reg_default(4'(i));
            end
            for (int unsigned j = 0; j < EXT_DEPTH; j++) begin
                ext_r[j] <= 8'h00;
            end
        end else if (commit_s && in_imm_s) begin
            imm_r[idx_s] <= wr_val_s;
        end else if (commit_s && in_ext_s) begin
            ext_r[ext_off_s[EW-1:0]] <= wdata_r;
        end
    end

    // Transaction capture, delay/soft-reset counter, sticky error and write observation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_r      <= 8'h00;
            ext_addr_r <= 8'h00;
            wdata_r    <= 8'h00;
            cnt_r      <= 16'd0;
            err_r      <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 8'h00;
            wr_data_r  <= 8'h00;
        end else begin
            if (seen_s) begin
                cmd_r <= ulpi.ulpi_data_i;
            end
            if (state_r == ST_ADDR) begin
                ext_addr_r <= ulpi.ulpi_data_i;
            end
            if (state_r == ST_WDATA) begin
                wdata_r <= ulpi.ulpi_data_i;
            end
            cnt_r      <= ((state_n == state_r) && ((state_r == ST_DELAY) || (state_r == ST_SRST)))
                          ? cnt_r + 16'd1 : 16'd0;
            err_r      <= err_r | err_set_s;
            wr_valid_r <= commit_s;
            if (commit_s) begin
                wr_addr_r <= acc_addr_s;
                wr_data_r <= wdata_r;
            end
        end
    end

    // Bus outputs registered from the state being entered so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_r  <= 1'b1;
            nxt_r  <= 1'b0;
            data_r <= 8'h00;
        end else begin
            dir_r  <= (state_n == ST_TURN1) || (state_n == ST_RDATA) || (state_n == ST_SRST);
            nxt_r  <= (state_n == ST_CMDACK) || (state_n == ST_ADDR) ||
                      (state_n == ST_WDATA) || (state_n == ST_TXNXT);
            data_r <= (state_n == ST_RDATA) ? rd_val_s : 8'h00;
        end
    end

    assign ulpi.ulpi_dir_o  = dir_r;
    assign ulpi.ulpi_nxt_o  = nxt_r;
    assign ulpi.ulpi_data_o = data_r;
    assign wr_valid_o       = wr_valid_r;
    assign wr_addr_o        = wr_addr_r;
    assign wr_data_o        = wr_data_r;
    assign err_o            = err_r;
endmodule

// File: tb/tb_oup_phymodel_regs.sv
// Bench for oup_phymodel_regs: a zero-latency instance and an NXT_DELAY=3
// instance share one link driver; sel picks which one is being exercised.
module tb_oup_phymodel_regs;
    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] link_data;
    logic       link_stp;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  exp_rd_q [$];
    logic [15:0] exp_wr_q [$];

    oup_phymodel_regs_if bus0 ();
    oup_phymodel_regs_if bus1 ();

    logic       wv0, wv1, err0, err1;
    logic [7:0] wa0, wd0, wa1, wd1;
    logic       mon_dir, mon_nxt, mon_wv, mon_err;
    logic [7:0] mon_data, mon_wa, mon_wd;

    always #5 clk = ~clk;

    assign bus0.ulpi_data_i = sel ? 8'h00 : link_data;
    assign bus0.ulpi_stp_i  = sel ? 1'b0 : link_stp;
    assign bus1.ulpi_data_i = sel ? link_data : 8'h00;
    assign bus1.ulpi_stp_i  = sel ? link_stp : 1'b0;

    assign mon_dir  = sel ? bus1.ulpi_dir_o  : bus0.ulpi_dir_o;
    assign mon_nxt  = sel ? bus1.ulpi_nxt_o  : bus0.ulpi_nxt_o;
    assign mon_data = sel ? bus1.ulpi_data_o : bus0.ulpi_data_o;
    assign mon_wv   = sel ? wv1  : wv0;
    assign mon_wa   = sel ? wa1  : wa0;
    assign mon_wd   = sel ? wd1  : wd0;
    assign mon_err  = sel ? err1 : err0;

    oup_phymodel_regs #(.NXT_DELAY(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .ulpi(bus0.slave),
        .wr_valid_o(wv0), .wr_addr_o(wa0), .wr_data_o(wd0), .err_o(err0)
    );

    oup_phymodel_regs #(.NXT_DELAY(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .ulpi(bus1.slave),
        .wr_valid_o(wv1), .wr_addr_o(wa1), .wr_data_o(wd1), .err_o(err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input logic s);
        sel = s;
        #1;
    endtask

    // Full REGW transaction; lat = cycles from command to first NXT.
    task automatic do_write(input bit ext, input logic [7:0] addr, input logic [7:0] data, output int lat);
        logic [15:0] e;
        link_stp  = 1'b0;
        link_data = ext ? 8'hAF : {2'b10, addr[5:0]};
        exp_wr_q.push_back({addr, data});
        step();
        lat = 1;
        while (mon_nxt !== 1'b1 && lat < 32) begin
            step();
            lat++;
        end
        tests_run++;
        if (mon_nxt !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_cmd_nxt addr=%02h got nxt=%b required 1 within 32 cycles", addr, mon_nxt);
            link_data = 8'h00;
            void'(exp_wr_q.pop_back());
            return;
        end
        step();
        if (ext) begin
            link_data = addr;
            tests_run++;
            if (mon_nxt !== 1'b1) begin
                tests_failed++;
                $display("FAIL wr_addr_nxt addr=%02h got=%b required=1", addr, mon_nxt);
            end
            step();
        end
        link_data = data;
        tests_run++;
        if (mon_nxt !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_data_nxt addr=%02h got=%b required=1", addr, mon_nxt);
        end
        step();
        link_data = 8'h00;
        link_stp  = 1'b1;
        tests_run++;
        if (mon_nxt !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_end_nxt addr=%02h got=%b required=0", addr, mon_nxt);
        end
        step();
        link_stp = 1'b0;
        e = exp_wr_q.pop_front();
        tests_run++;
        if (mon_wv !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_valid addr=%02h got=%b required=1", addr, mon_wv);
        end else if ({mon_wa, mon_wd} !== e) begin
            tests_failed++;
            $display("FAIL wr_obs got addr/data=%02h/%02h required=%02h/%02h", mon_wa, mon_wd, e[15:8], e[7:0]);
        end
    endtask

    // Full REGR transaction; the expected byte is queued at issue and checked in RDATA.
    task automatic do_read(input bit ext, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] e;
        int         lat;
        link_stp  = 1'b0;
        link_data = ext ? 8'hEF : {2'b11, addr[5:0]};
        exp_rd_q.push_back(exp);
        step();
        lat = 1;
        while (mon_nxt !== 1'b1 && lat < 32) begin
            step();
            lat++;
        end
        tests_run++;
        if (mon_nxt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_cmd_nxt addr=%02h got nxt=%b required 1 within 32 cycles", addr, mon_nxt);
            link_data = 8'h00;
            void'(exp_rd_q.pop_back());
            return;
        end
        step();
        if (ext) begin
            link_data = addr;
            step();
        end
        link_data = 8'h00;
        tests_run++;
        if (mon_dir !== 1'b1 || mon_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rd_turn1 addr=%02h got dir/data=%b/%02h required=1/00", addr, mon_dir, mon_data);
        end
        step();
        e = exp_rd_q.pop_front();
        tests_run++;
        if (mon_dir !== 1'b1 || mon_data !== e) begin
            tests_failed++;
            $display("FAIL rd_data addr=%02h got dir/data=%b/%02h required=1/%02h", addr, mon_dir, mon_data, e);
        end
        step();
        tests_run++;
        if (mon_dir !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_turn2 addr=%02h got dir=%b required=0", addr, mon_dir);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        link_data = 8'h00;
        link_stp  = 1'b0;
        pick(1'b0);
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            pick(s[0]);
            tests_run++;
            if (mon_dir !== 1'b1 || mon_nxt !== 1'b0 || mon_data !== 8'h00 || mon_wv !== 1'b0 || mon_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs dut%0d got dir/nxt/data/wv/err=%b/%b/%02h/%b/%b required=1/0/00/0/0",
                         s, mon_dir, mon_nxt, mon_data, mon_wv, mon_err);
            end
        end
        rst = 1'b0;
        step();
        for (int s = 0; s < 2; s++) begin
            pick(s[0]);
            tests_run++;
            if (mon_dir !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_release_dir dut%0d got=%b required=0", s, mon_dir);
            end
        end
        pick(1'b0);
        do_read(1'b0, 8'h00, 8'hCD);
        do_read(1'b0, 8'h01, 8'hAB);
        do_read(1'b0, 8'h02, 8'h34);
        do_read(1'b0, 8'h03, 8'h12);
        do_read(1'b0, 8'h04, 8'h41);
        do_read(1'b0, 8'h0A, 8'h06);
        do_read(1'b0, 8'h10, 8'h1F);
        do_read(1'b0, 8'h13, 8'h00);
    endtask

    task automatic test_scratch_write();
        int lat;
        pick(1'b0);
        do_write(1'b0, 8'h16, 8'h5A, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL nxt_latency_d0 got=%0d required=1", lat);
        end
        do_read(1'b0, 8'h16, 8'h5A);
        do_read(1'b1, 8'h16, 8'h5A);
    endtask

    task automatic test_set_clear();
        int lat;
        pick(1'b0);
        do_write(1'b0, 8'h0B, 8'h81, lat);
        do_read(1'b0, 8'h0A, 8'h87);
        do_write(1'b0, 8'h0C, 8'h06, lat);
        do_read(1'b0, 8'h0A, 8'h81);
        do_read(1'b0, 8'h0B, 8'h81);
        do_read(1'b0, 8'h0C, 8'h81);
    endtask

    task automatic test_ext_delay();
        int lat;
        pick(1'b1);
        do_write(1'b1, 8'h45, 8'h3C, lat);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL nxt_latency_d3 got=%0d required=4", lat);
        end
        do_read(1'b1, 8'h45, 8'h3C);
        do_write(1'b1, 8'h4F, 8'hA5, lat);
        do_read(1'b1, 8'h4F, 8'hA5);
        do_write(1'b1, 8'h50, 8'h77, lat);
        do_read(1'b1, 8'h50, 8'h00);
        do_read(1'b1, 8'h01, 8'hAB);
        tests_run++;
        if (mon_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ext_err got=%b required=0", mon_err);
        end
    endtask

    task automatic test_abort_err();
        int lat;
        pick(1'b0);
        link_stp  = 1'b0;
        link_data = 8'h96;
        step();
        lat = 1;
        while (mon_nxt !== 1'b1 && lat < 32) begin
            step();
            lat++;
        end
        step();
        link_data = 8'h11;
        link_stp  = 1'b1;
        step();
        link_stp  = 1'b0;
        link_data = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (mon_wv !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort_wr_valid cycle=%0d got=%b required=0", k, mon_wv);
            end
            step();
        end
        tests_run++;
        if (mon_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_err got=%b required=0", mon_err);
        end
        do_read(1'b0, 8'h16, 8'h5A);
        link_data = 8'h05;
        step();
        link_data = 8'h00;
        step();
        tests_run++;
        if (mon_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL reserved_cmd_err got=%b required=1", mon_err);
        end
        repeat (4) step();
        do_read(1'b0, 8'h04, 8'h41);
        tests_run++;
        if (mon_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky got=%b required=1", mon_err);
        end
    endtask

    task automatic test_soft_reset();
        int lat;
        int n;
        pick(1'b0);
        do_write(1'b0, 8'h05, 8'h20, lat);
        n = 0;
        while (mon_dir === 1'b1 && n < 20) begin
            n++;
            step();
        end
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL soft_reset_dir_cycles got=%0d required=4", n);
        end
        tests_run++;
        if (mon_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL soft_reset_err_kept got=%b required=1", mon_err);
        end
        do_read(1'b0, 8'h04, 8'h41);
        do_read(1'b0, 8'h16, 8'h00);
        do_read(1'b0, 8'h0A, 8'h06);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        link_data = 8'h00;
        link_stp  = 1'b0;
        test_reset();
        test_scratch_write();
        test_set_clear();
        test_ext_delay();
        test_abort_err();
        test_soft_reset();
        tests_run++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got rd/wr left=%0d/%0d required=0/0", exp_rd_q.size(), exp_wr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
